// File: rtl/vit_trb_decision_pipe.sv
// Best-survivor selector for the Viterbi traceback: pipelined binary min/max tree over
// modular path metrics, with a per-word forced-state bypass and sop/eop tags carried alongside.
module vit_trb_decision_pipe #(
    parameter int pCONSTR_LENGTH = 7,
    parameter int pMETRIC_W      = 10,
    parameter int pMAX_MODE      = 0,
    parameter int pREG_EVERY     = 2
) (
    input  logic                                             iclk,
    input  logic                                             ireset,
    input  logic                                             iclkena,
    input  logic                                             ival,
    input  logic                                             isop,
    input  logic                                             ieop,
    input  logic                                             imode,
    input  logic [pCONSTR_LENGTH-2:0]                        itail_state,
    input  logic [(1 << (pCONSTR_LENGTH-1))*pMETRIC_W-1:0]   istatem,
    output logic                                             oval,
    output logic                                             osop,
    output logic                                             oeop,
    output logic [pCONSTR_LENGTH-2:0]                        ostate,
    output logic [pMETRIC_W-1:0]                             ometric
);

    localparam int cD         = pCONSTR_LENGTH - 1;
    localparam int pSTATE_NUM = 1 << cD;

    // Valid semantics: a word is accepted in every cycle where iclkena=1 and ival=1; there is no
    // ready, the block never stalls. oval marks the cycle in which ostate/ometric/osop/oeop hold it.
    typedef struct packed {
        logic                 val;
        logic                 sop;
        logic                 eop;
        logic                 mode;
        logic [cD-1:0]        tail;
        logic [pMETRIC_W-1:0] fmet;
    } side_t;

    for (genvar l = 1; l <= cD; l++) begin : gen_lvl
        localparam int cN   = pSTATE_NUM >> l;
        localparam bit cREG = ((l % pREG_EVERY) == 0) || (l == cD);

        logic [pMETRIC_W-1:0] in_met  [2*cN];
        logic [cD-1:0]        in_idx  [2*cN];
        side_t                in_side;
        logic [pMETRIC_W-1:0] nd_met  [cN];
        logic [cD-1:0]        nd_idx  [cN];
        logic [pMETRIC_W-1:0] out_met [cN];
        logic [cD-1:0]        out_idx [cN];
        side_t                out_side;

        if (l == 1) begin : g_src
            for (genvar k = 0; k < 2*cN; k++) begin : g_k
                assign in_met[k] = istatem[k*pMETRIC_W +: pMETRIC_W];
                assign in_idx[k] = cD'(k);
            end
            assign in_side.val  = ival;
            assign in_side.sop  = isop;
            assign in_side.eop  = ieop;
            assign in_side.mode = imode;
            assign in_side.tail = itail_state;
            assign in_side.fmet = in_met[itail_state];
        end else begin : g_src
            for (genvar k = 0; k < 2*cN; k++) begin : g_k
                assign in_met[k] = gen_lvl[l-1].out_met[k];
                assign in_idx[k] = gen_lvl[l-1].out_idx[k];
            end
            assign in_side = gen_lvl[l-1].out_side;
        end

        // The even child always covers lower indices, so it keeps the node on equal metrics.
        for (genvar j = 0; j < cN; j++) begin : g_nd
            logic [pMETRIC_W-1:0] d;
            logic                 sel_b;
            assign d      = in_met[2*j] - in_met[2*j+1];
            assign sel_b  = (pMAX_MODE != 0) ? d[pMETRIC_W-1]
                                             : (!d[pMETRIC_W-1] && (d != '0));
            assign nd_met[j] = sel_b ? in_met[2*j+1] : in_met[2*j];
            assign nd_idx[j] = sel_b ? in_idx[2*j+1] : in_idx[2*j];
        end

        if (cREG) begin : g_reg
            always_ff @(posedge iclk) begin
                if (ireset) begin
                    for (int j = 0; j < cN; j++) begin
                        out_met[j] <= '0;
                        out_idx[j] <= '0;
                    end
                    out_side <= '0;
                end else if (iclkena) begin
                    for (int j = 0; j < cN; j++) begin
                        out_met[j] <= nd_met[j];
                        out_idx[j] <= nd_idx[j];
                    end
                    out_side <= in_side;
                    if ((l == cD) && in_side.mode) begin
                        out_met[0] <= in_side.fmet;
                        out_idx[0] <= in_side.tail;
                    end
                end
            end
        end else begin : g_comb
            for (genvar j = 0; j < cN; j++) begin : g_j
                assign out_met[j] = nd_met[j];
                assign out_idx[j] = nd_idx[j];
            end
            assign out_side = in_side;
        end
    end

    assign oval    = gen_lvl[cD].out_side.val;
    assign osop    = gen_lvl[cD].out_side.sop;
    assign oeop    = gen_lvl[cD].out_side.eop;
    assign ostate  = gen_lvl[cD].out_idx[0];
    assign ometric = gen_lvl[cD].out_met[0];

    // Forced-mode fields have already been folded into the last stage's data.
    logic side_unused;
    assign side_unused = ^{gen_lvl[cD].out_side.mode, gen_lvl[cD].out_side.tail,
                           gen_lvl[cD].out_side.fmet};

endmodule
